piso_frame_tx: RTL
==================

// Module: piso_frame_tx
// PURPOSE
//  Parametrised parallel-in/serial-out frame serializer; next generation of the team's 11-bit MSB-first PISO.
//  Wraps DW data bits into a start/data/parity/stop frame and shifts it out one bit per baud tick.
//  Bit order is selectable per frame. A valid/ready input handshake and done/busy status let the TX FSM
//  stream frames back-to-back. Sits between the TX controller and the serial line pin.
// PARAMETERS
//  DW         8  data bits per frame (>=1)
//  PARITY     1  0=none, 1=even, 2=odd
//  STOP_BITS  1  number of stop bits (1 or 2)
//  FL         frame length, derived: 1 + DW + (PARITY!=0) + STOP_BITS (default 11); not overridable
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous reset, active low
//  tick       in   1         baud enable; one serial bit per tick while shifting
//  flush      in   1         synchronous abort of the frame in progress
//  msb_first  in   1         bit order, sampled at load: 1=MSB first, 0=LSB first
//  in_valid   in   1         data word available
//  in_data    in   DW        parallel data word
//  in_ready   out  1         block can accept a word this cycle
//  out        out  1         serial line; idles high
//  busy       out  1         frame in progress
//  done       out  1         one-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  Reset: state IDLE, shift register all 1s, bit counter 0. out=1, busy=0, done=0, in_ready=1.
//  States: IDLE, SHIFT (enum in package).
//   IDLE:  in_ready=1. When in_valid=1, at the next edge:
//          - the frame is loaded: {start=0, data in chosen order, parity, stop 1s};
//          - counter=0, state -> SHIFT.
//   SHIFT: out = current frame bit (start bit immediately after load).
//          - Each tick=1 advances one bit. A tick in the accept cycle is ignored; tick=0 holds.
//          - The edge consuming the FL-th tick sets state -> IDLE and done=1 for exactly that next cycle.
//  Back-to-back: in_ready=1 in the done cycle. A word offered then loads at the next edge, so there is no idle gap.
//  Parity is computed over the DW data bits only: even -> ^data; odd -> ~^data.
//  Shift fill value is 1, so the line returns high after the stop bits.
//  Shift register: FL bits; out = MSB of the register.
//   - data order is resolved at load time (bit-reversed when msb_first=0);
//   - shifting is always toward the MSB.
//  Counter width: $clog2(FL+1). Counter never wraps. It is cleared on load and on flush.
//  flush=1:
//   - out is forced to 1 combinationally in the same cycle;
//   - next edge: state IDLE, register all 1s, no done pulse;
//   - in_valid is ignored while flush=1, so flush has priority over load and tick.
//  in_data/msb_first changes during SHIFT have no effect on the frame in flight.
//  Async reset mid-frame: immediately returns to the reset values above; no done pulse.
//  busy = (state==SHIFT); in_ready = (state==IDLE) & ~flush.
// STRUCTURE
//  piso_frame_pkg:
//   - state_e {IDLE, SHIFT};
//   - parity enum {PAR_NONE, PAR_EVEN, PAR_ODD};
//   - function frame_len(DW, PARITY, STOP_BITS).
//  One sub-module, frame_bit_cnt: a parametrised up-counter with clear, enable and terminal-count flag (TC at FL).
//  Frame assembly (ordering, parity) is combinational logic in the top module.
// TESTING
//  1 Reset released, no stimulus -> out=1, busy=0, in_ready=1, done=0 for 20 cycles.
//  2 DW=8, even parity, in_data=8'h13, msb_first=0, tick every 4 clk
//    -> out per tick 0,1,1,0,0,1,0,0,0,1,1; done after 11th tick.
//  3 Same word with msb_first=1 -> 0,0,0,0,1,0,0,1,1,1,1; parity bit=1 (three ones).
//  4 PARITY=2 (odd), in_data=8'h00 -> parity bit 1; STOP_BITS=2 gives FL=12 with two trailing 1s.
//  5 in_valid held high, tick every clk -> frames contiguous; done pulses exactly every 11 tick-edges;
//    in_ready=1 only in done cycles.
//  6 flush asserted at bit 5 -> out=1 same cycle, IDLE next edge, no done.
//    Async reset at bit 3 -> out=1, busy=0 immediately.

Source files
------------

// File: rtl/piso_frame_tx_pkg.sv
// Shared types and helpers for the PISO frame serializer.
package piso_frame_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Total serial bits per frame: start + data + optional parity + stop.
    function automatic int unsigned frame_len(input int unsigned dw,
                                              input int unsigned parity,
                                              input int unsigned stop_bits);
        return 32'd1 + dw + ((parity != 32'd0) ? 32'd1 : 32'd0) + stop_bits;
    endfunction

endpackage

// File: rtl/piso_frame_tx_if.sv
// Parallel word handshake between the TX controller and the serializer.
interface piso_frame_tx_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_frame_tx_frame_bit_cnt.sv
// Saturating bit counter; tc_c flags the enable that brings the count to MAX.
module frame_bit_cnt #(
    parameter int unsigned MAX = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc_c
);
    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    // Count enabled bits, clear has priority, never wrap past MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(MAX))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc_c = en && (cnt == CW'(MAX - 1));

endmodule

// File: rtl/piso_frame_tx.sv
// Frame serializer: loads start/data/parity/stop into a shift register and
// shifts it out MSB-of-register first, one bit per baud tick.
module piso_frame_tx
    import piso_frame_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned PARITY    = 1,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                flush,
    input  logic                msb_first,
    piso_frame_tx_if.slave      bus,
    output logic                out,
    output logic                busy,
    output logic                done
);
    localparam int unsigned FL = frame_len(DW, PARITY, STOP_BITS);

    state_e        state;
    logic [FL-1:0] sr;
    logic [FL-1:0] frame_c;
    logic [DW-1:0] data_ord_c;
    logic          par_bit_c;
    logic          load_c;
    logic          adv_c;
    logic          last_c;

    assign load_c = (state == IDLE) && bus.in_valid && !flush;
    assign adv_c  = (state == SHIFT) && tick && !flush;

    frame_bit_cnt #(.MAX(FL)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (load_c | flush),
        .en    (adv_c),
        .tc_c  (last_c)
    );

    // Assemble the frame image; data order is fixed here so shifting is one-way.
    always_comb begin
        data_ord_c = bus.in_data;
        if (!msb_first) begin
            for (int i = 0; i < int'(DW); i++) begin
                data_ord_c[i] = bus.in_data[int'(DW) - 1 - i];
            end
        end
        par_bit_c = (PARITY == 32'(PAR_ODD)) ? ~^bus.in_data : ^bus.in_data;
        frame_c = '1;
        frame_c[FL-1] = 1'b0;
        frame_c[FL-2 -: DW] = data_ord_c;
        if (PARITY != 32'(PAR_NONE)) begin
            frame_c[FL-2-DW] = par_bit_c;
        end
    end

    // Control FSM and shift register; flush outranks load and tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sr    <= '1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                sr    <= '1;
            end else if (load_c) begin
                state <= SHIFT;
                sr    <= frame_c;
            end else if (adv_c) begin
                sr <= {sr[FL-2:0], 1'b1};
                if (last_c) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign out          = flush | sr[FL-1];
    assign busy         = (state == SHIFT);
    assign bus.in_ready = (state == IDLE) && !flush;

endmodule
